// File: rtl/dvp_pkg.sv
// Shared types and sizing helpers for the DVP frame receiver.
package dvp_pkg;

  localparam int PIXEL_BITS_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VS     = 2'd1,
    ST_ACTIVE = 2'd2
  } dvp_state_t;

  // Packed so that {eof, eol, sof} sits directly above the pixel word in the FIFO.
  typedef struct packed {
    logic eof;
    logic eol;
    logic sof;
  } pix_tag_t;

  // Bits needed to hold a counter that runs from 0 up to and including max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Bits needed to address depth entries (depth is a power of two).
  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/dvp_frame_rx_fifo.sv
// First-word fall-through synchronous FIFO; head entry is always visible on o_rdata.
module sync_fifo_fwft
  import dvp_pkg::*;
#(
  parameter int WIDTH = 19,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = ptr_width(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  // A push into a full FIFO is still taken when the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_rdata   = r_mem[r_rd_ptr];

  // Storage array; contents need no reset since occupancy is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dvp_frame_rx.sv
// DVP pixel-bus receiver: recovers frame/line framing from vsync/href, checks
// geometry, and streams tagged pixels out through a FWFT FIFO.
module dvp_frame_rx
  import dvp_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIXEL_BITS = PIXEL_BITS_DEF,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vsync,
  input  logic                  href,
  input  logic [PIXEL_BITS-1:0] pixel_in,
  input  logic                  err_clear,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [PIXEL_BITS-1:0] m_data,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  m_eof,
  output logic                  frame_done,
  output logic [15:0]           frame_count,
  output logic                  err_short_line,
  output logic                  err_long_line,
  output logic                  err_short_frame,
  output logic                  err_overflow
);

  localparam int COL_W = cnt_width(IMG_WIDTH);
  localparam int ROW_W = cnt_width(IMG_HEIGHT);
  localparam int FW    = PIXEL_BITS + 3;

  localparam logic [COL_W-1:0] COL_LIMIT = COL_W'(IMG_WIDTH);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);

  // Input capture and edge history
  logic                  r_vs, r_vs_d, r_hr, r_hr_d;
  logic [PIXEL_BITS-1:0] r_px;
  logic                  w_vs_rise, w_vs_fall, w_hr_fall;

  // Framing state
  dvp_state_t       r_state, w_state_next;
  logic [COL_W-1:0] r_col, w_col_next;
  logic [ROW_W-1:0] r_row, w_row_next;
  logic             r_line_err, w_line_err_next;

  // Per-cycle events
  logic     w_push, w_long, w_short, w_short_frame, w_frame_end, w_frame_good;
  pix_tag_t w_tag;

  // Status registers
  logic        r_frame_done;
  logic [15:0] r_frame_count;
  logic        r_err_short_line, r_err_long_line, r_err_short_frame, r_err_overflow;

  // FIFO interface
  logic          w_fifo_full, w_fifo_empty, w_pop, w_overflow;
  logic [FW-1:0] w_fifo_rdata;

  // Register the pins and keep one cycle of history for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs   <= 1'b0;
      r_vs_d <= 1'b0;
      r_hr   <= 1'b0;
      r_hr_d <= 1'b0;
      r_px   <= '0;
    end else begin
      r_vs   <= vsync;
      r_vs_d <= r_vs;
      r_hr   <= href;
      r_hr_d <= r_hr;
      r_px   <= pixel_in;
    end
  end

  assign w_vs_rise = r_vs & ~r_vs_d;
  assign w_vs_fall = ~r_vs & r_vs_d;
  assign w_hr_fall = ~r_hr & r_hr_d;

  // Tags describe the position of the pixel being pushed this cycle.
  assign w_tag.sof = (r_row == '0) && (r_col == '0);
  assign w_tag.eol = (r_col == COL_LAST);
  assign w_tag.eof = (r_col == COL_LAST) && (r_row == ROW_LAST);

  // Framing state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_col      <= '0;
      r_row      <= '0;
      r_line_err <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_col      <= w_col_next;
      r_row      <= w_row_next;
      r_line_err <= w_line_err_next;
    end
  end

  // Next-state, counter updates and per-cycle framing events.
  always_comb begin
    w_state_next    = r_state;
    w_col_next      = r_col;
    w_row_next      = r_row;
    w_line_err_next = r_line_err;
    w_push          = 1'b0;
    w_long          = 1'b0;
    w_short         = 1'b0;
    w_short_frame   = 1'b0;
    w_frame_end     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_vs_rise) w_state_next = ST_VS;
      end
      ST_VS: begin
        if (w_vs_fall) begin
          w_state_next    = ST_ACTIVE;
          w_col_next      = '0;
          w_row_next      = '0;
          w_line_err_next = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (w_vs_rise) begin
          // A new frame starts before this one finished; abandon it.
          w_short_frame = 1'b1;
          w_state_next  = ST_VS;
        end else begin
          if (r_hr) begin
            if (r_col < COL_LIMIT) begin
              w_push     = 1'b1;
              w_col_next = r_col + COL_W'(1);
            end else begin
              w_long = 1'b1;
            end
          end
          if (w_hr_fall) begin
            w_short    = (r_col != COL_LIMIT);
            w_col_next = '0;
            w_row_next = r_row + ROW_W'(1);
            if (r_row == ROW_LAST) begin
              w_frame_end  = 1'b1;
              w_state_next = ST_IDLE;
            end
          end
          if (w_long || w_short) w_line_err_next = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // The line that closes the frame may itself be short, so fold it in directly.
  assign w_frame_good = w_frame_end & ~r_line_err & ~w_short;

  assign w_pop      = m_valid & m_ready;
  assign w_overflow = w_push & w_fifo_full & ~w_pop;

  // Frame completion pulse, good-frame counter and sticky errors (new events beat err_clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_done      <= 1'b0;
      r_frame_count     <= '0;
      r_err_short_line  <= 1'b0;
      r_err_long_line   <= 1'b0;
      r_err_short_frame <= 1'b0;
      r_err_overflow    <= 1'b0;
    end else begin
      r_frame_done      <= w_frame_end;
      r_frame_count     <= r_frame_count + {15'd0, w_frame_good};
      r_err_short_line  <= (r_err_short_line  & ~err_clear) | w_short;
      r_err_long_line   <= (r_err_long_line   & ~err_clear) | w_long;
      r_err_short_frame <= (r_err_short_frame & ~err_clear) | w_short_frame;
      r_err_overflow    <= (r_err_overflow    & ~err_clear) | w_overflow;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata ({w_tag, r_px}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign m_valid = ~w_fifo_empty;
  assign {m_eof, m_eol, m_sof, m_data} = w_fifo_rdata;

  assign frame_done      = r_frame_done;
  assign frame_count     = r_frame_count;
  assign err_short_line  = r_err_short_line;
  assign err_long_line   = r_err_long_line;
  assign err_short_frame = r_err_short_frame;
  assign err_overflow    = r_err_overflow;

endmodule

// File: tb/tb_dvp_frame_rx.sv
// Directed bench for dvp_frame_rx with an 8x4 image; a second instance with a
// deep FIFO is used for the toggling-backpressure scenario.
module tb_dvp_frame_rx;

  localparam int W = 8;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst, vsync, href, err_clear, m_ready, m_ready_b;
  logic [15:0] pixel_in;

  logic        m_valid, m_sof, m_eol, m_eof, frame_done;
  logic [15:0] m_data, frame_count;
  logic        err_short_line, err_long_line, err_short_frame, err_overflow;

  logic        m_valid_b, m_sof_b, m_eol_b, m_eof_b, frame_done_b;
  logic [15:0] m_data_b, frame_count_b;
  logic        err_short_line_b, err_long_line_b, err_short_frame_b, err_overflow_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dvp_frame_rx #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_BITS(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .href(href), .pixel_in(pixel_in),
    .err_clear(err_clear), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof), .frame_done(frame_done),
    .frame_count(frame_count), .err_short_line(err_short_line),
    .err_long_line(err_long_line), .err_short_frame(err_short_frame),
    .err_overflow(err_overflow)
  );

  dvp_frame_rx #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_BITS(16), .FIFO_DEPTH(64)) dut_b (
    .clk(clk), .rst(rst), .vsync(vsync), .href(href), .pixel_in(pixel_in),
    .err_clear(err_clear), .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b),
    .m_sof(m_sof_b), .m_eol(m_eol_b), .m_eof(m_eof_b), .frame_done(frame_done_b),
    .frame_count(frame_count_b), .err_short_line(err_short_line_b),
    .err_long_line(err_long_line_b), .err_short_frame(err_short_frame_b),
    .err_overflow(err_overflow_b)
  );

  // Output capture, sampled on the falling edge.
  logic [15:0] cap_d[$];
  logic [2:0]  cap_t[$];
  logic [15:0] cap_d_b[$];
  logic [2:0]  cap_t_b[$];
  int          fd_cnt = 0;
  int          stall_viol = 0;
  logic        stall_prev = 1'b0;
  logic [18:0] hold_b = '0;

  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      cap_d.push_back(m_data);
      cap_t.push_back({m_eof, m_eol, m_sof});
    end
    if (frame_done) fd_cnt++;
    if (m_valid_b && m_ready_b) begin
      cap_d_b.push_back(m_data_b);
      cap_t_b.push_back({m_eof_b, m_eol_b, m_sof_b});
    end
    if (stall_prev && ({m_eof_b, m_eol_b, m_sof_b, m_data_b} !== hold_b)) stall_viol++;
    stall_prev = m_valid_b && !m_ready_b;
    hold_b     = {m_eof_b, m_eol_b, m_sof_b, m_data_b};
  end

  function automatic logic [15:0] get_d(input int idx);
    return (idx < cap_d.size()) ? cap_d[idx] : 16'hxxxx;
  endfunction
  function automatic logic [2:0] get_t(input int idx);
    return (idx < cap_t.size()) ? cap_t[idx] : 3'bxxx;
  endfunction
  function automatic logic [15:0] get_d_b(input int idx);
    return (idx < cap_d_b.size()) ? cap_d_b[idx] : 16'hxxxx;
  endfunction
  function automatic logic [2:0] get_t_b(input int idx);
    return (idx < cap_t_b.size()) ? cap_t_b[idx] : 3'bxxx;
  endfunction

  // Stimulus helpers
  int pix_val = 0;

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; vsync = 1'b0; href = 1'b0; pixel_in = '0; err_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic vs_pulse();
    @(posedge clk); #1 vsync = 1'b1;
    @(posedge clk); #1 vsync = 1'b0;
    idle(2);
  endtask

  task automatic send_line(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      href     = 1'b1;
      pixel_in = pix_val[15:0];
      pix_val++;
    end
    @(posedge clk); #1;
    href     = 1'b0;
    pixel_in = '0;
  endtask

  task automatic send_frame(input int l0, input int l1, input int l2, input int l3);
    vs_pulse();
    send_line(l0);
    send_line(l1);
    send_line(l2);
    send_line(l3);
  endtask

  // Scenarios
  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1; vsync = 1'b1; href = 1'b1; pixel_in = 16'hBEEF;
    err_clear = 1'b0; m_ready = 1'b1; m_ready_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", m_valid); end
    checks++;
    if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0h expected 0", frame_count); end
    checks++;
    if ({err_short_line, err_long_line, err_short_frame, err_overflow} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_errs: got %4b expected 0000",
               {err_short_line, err_long_line, err_short_frame, err_overflow});
    end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", frame_done); end
    @(posedge clk); #1;
    rst = 1'b0; vsync = 1'b0; href = 1'b0; pixel_in = '0;
    $display("test_reset done");
  endtask

  task automatic test_clean_frame();
    int s, f0;
    do_reset();
    m_ready = 1'b1; m_ready_b = 1'b1;
    s = cap_d.size(); f0 = fd_cnt; pix_val = 0;
    send_frame(8, 8, 8, 8);
    idle(10);
    checks++;
    if (cap_d.size() - s !== 32) begin errors++; $display("FAIL clean_count: got %0d expected 32", cap_d.size() - s); end
    for (int i = 0; i < 32; i++) begin
      logic [2:0] et;
      et = {(i == 31), (i % 8 == 7), (i == 0)};
      checks++;
      if (get_d(s + i) !== i[15:0]) begin errors++; $display("FAIL clean_data[%0d]: got %0h expected %0h", i, get_d(s + i), i); end
      checks++;
      if (get_t(s + i) !== et) begin errors++; $display("FAIL clean_tag[%0d]: got %3b expected %3b", i, get_t(s + i), et); end
    end
    checks++;
    if (fd_cnt - f0 !== 1) begin errors++; $display("FAIL clean_frame_done: got %0d expected 1", fd_cnt - f0); end
    checks++;
    if (frame_count !== 16'd1) begin errors++; $display("FAIL clean_frame_count: got %0h expected 1", frame_count); end
    checks++;
    if ({err_short_line, err_long_line, err_short_frame, err_overflow} !== 4'b0000) begin
      errors++;
      $display("FAIL clean_errs: got %4b expected 0000",
               {err_short_line, err_long_line, err_short_frame, err_overflow});
    end
    $display("test_clean_frame done: %0d words", cap_d.size() - s);
  endtask

  task automatic test_backpressure();
    int s, sb, v0;
    do_reset();
    m_ready = 1'b0; m_ready_b = 1'b1;
    sb = cap_d_b.size(); v0 = stall_viol; pix_val = 0;
    fork
      send_frame(8, 8, 8, 8);
      begin
        for (int k = 0; k < 150; k++) begin
          @(posedge clk); #1 m_ready_b = ~m_ready_b;
        end
      end
    join
    m_ready_b = 1'b1;
    idle(4);
    @(negedge clk);
    checks++;
    if (err_overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow4: got %0b expected 1", err_overflow); end
    checks++;
    if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_valid4: got %0b expected 1", m_valid); end
    s = cap_d.size();
    @(posedge clk); #1 m_ready = 1'b1;
    idle(8);
    checks++;
    if (cap_d.size() - s !== 4) begin errors++; $display("FAIL bp_kept4: got %0d expected 4", cap_d.size() - s); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (get_d(s + i) !== i[15:0]) begin errors++; $display("FAIL bp_data4[%0d]: got %0h expected %0h", i, get_d(s + i), i); end
    end
    checks++;
    if (cap_d_b.size() - sb !== 32) begin errors++; $display("FAIL bp_count64: got %0d expected 32", cap_d_b.size() - sb); end
    for (int i = 0; i < 32; i++) begin
      logic [2:0] et;
      et = {(i == 31), (i % 8 == 7), (i == 0)};
      checks++;
      if (get_d_b(sb + i) !== i[15:0]) begin errors++; $display("FAIL bp_data64[%0d]: got %0h expected %0h", i, get_d_b(sb + i), i); end
      checks++;
      if (get_t_b(sb + i) !== et) begin errors++; $display("FAIL bp_tag64[%0d]: got %3b expected %3b", i, get_t_b(sb + i), et); end
    end
    checks++;
    if (stall_viol - v0 !== 0) begin errors++; $display("FAIL bp_stable64: got %0d changes expected 0", stall_viol - v0); end
    checks++;
    if (err_overflow_b !== 1'b0) begin errors++; $display("FAIL bp_overflow64: got %0b expected 0", err_overflow_b); end
    $display("test_backpressure done: %0d deep-fifo words", cap_d_b.size() - sb);
  endtask

  task automatic test_short_line();
    int s, f0, n_eol;
    do_reset();
    m_ready = 1'b1; m_ready_b = 1'b1;
    s = cap_d.size(); f0 = fd_cnt; pix_val = 0;
    send_frame(8, 6, 8, 8);
    idle(10);
    checks++;
    if (cap_d.size() - s !== 30) begin errors++; $display("FAIL sl_count: got %0d expected 30", cap_d.size() - s); end
    n_eol = 0;
    for (int i = s; i < cap_t.size(); i++) if (cap_t[i][1]) n_eol++;
    checks++;
    if (n_eol !== 3) begin errors++; $display("FAIL sl_eol_count: got %0d expected 3", n_eol); end
    checks++;
    if (get_t(s + 13) !== 3'b000) begin errors++; $display("FAIL sl_row1_end_tag: got %3b expected 000", get_t(s + 13)); end
    checks++;
    if (get_d(s + 21) !== 16'd21 || get_t(s + 21) !== 3'b010) begin
      errors++; $display("FAIL sl_row2_eol: got %0h/%3b expected 15/010", get_d(s + 21), get_t(s + 21));
    end
    checks++;
    if (get_t(s + 29) !== 3'b110) begin errors++; $display("FAIL sl_eof: got %3b expected 110", get_t(s + 29)); end
    checks++;
    if (err_short_line !== 1'b1) begin errors++; $display("FAIL sl_err: got %0b expected 1", err_short_line); end
    checks++;
    if (err_long_line !== 1'b0) begin errors++; $display("FAIL sl_long_err: got %0b expected 0", err_long_line); end
    checks++;
    if (fd_cnt - f0 !== 1) begin errors++; $display("FAIL sl_frame_done: got %0d expected 1", fd_cnt - f0); end
    checks++;
    if (frame_count !== 16'd0) begin errors++; $display("FAIL sl_frame_count: got %0h expected 0", frame_count); end
    $display("test_short_line done: %0d words", cap_d.size() - s);
  endtask

  task automatic test_long_line();
    int s;
    do_reset();
    m_ready = 1'b1; m_ready_b = 1'b1;
    s = cap_d.size(); pix_val = 0;
    send_frame(8, 8, 10, 8);
    idle(10);
    checks++;
    if (cap_d.size() - s !== 32) begin errors++; $display("FAIL ll_count: got %0d expected 32", cap_d.size() - s); end
    checks++;
    if (get_d(s + 23) !== 16'h0017 || get_t(s + 23) !== 3'b010) begin
      errors++; $display("FAIL ll_row2_eol: got %0h/%3b expected 17/010", get_d(s + 23), get_t(s + 23));
    end
    checks++;
    if (get_d(s + 24) !== 16'h001A) begin errors++; $display("FAIL ll_row3_first: got %0h expected 1a", get_d(s + 24)); end
    checks++;
    if (get_d(s + 31) !== 16'h0021 || get_t(s + 31) !== 3'b110) begin
      errors++; $display("FAIL ll_eof: got %0h/%3b expected 21/110", get_d(s + 31), get_t(s + 31));
    end
    checks++;
    if (err_long_line !== 1'b1) begin errors++; $display("FAIL ll_err: got %0b expected 1", err_long_line); end
    checks++;
    if (err_short_line !== 1'b0) begin errors++; $display("FAIL ll_short_err: got %0b expected 0", err_short_line); end
    checks++;
    if (frame_count !== 16'd0) begin errors++; $display("FAIL ll_frame_count: got %0h expected 0", frame_count); end
    $display("test_long_line done: %0d words", cap_d.size() - s);
  endtask

  task automatic test_short_frame();
    int s, f0;
    do_reset();
    m_ready = 1'b1; m_ready_b = 1'b1;
    s = cap_d.size(); f0 = fd_cnt; pix_val = 0;
    vs_pulse();
    send_line(8);
    send_line(8);
    pix_val = 32;
    send_frame(8, 8, 8, 8);
    idle(10);
    checks++;
    if (cap_d.size() - s !== 48) begin errors++; $display("FAIL sf_count: got %0d expected 48", cap_d.size() - s); end
    checks++;
    if (get_d(s + 16) !== 16'h0020 || get_t(s + 16) !== 3'b001) begin
      errors++; $display("FAIL sf_second_sof: got %0h/%3b expected 20/001", get_d(s + 16), get_t(s + 16));
    end
    checks++;
    if (get_d(s + 47) !== 16'h003F || get_t(s + 47) !== 3'b110) begin
      errors++; $display("FAIL sf_eof: got %0h/%3b expected 3f/110", get_d(s + 47), get_t(s + 47));
    end
    checks++;
    if (err_short_frame !== 1'b1) begin errors++; $display("FAIL sf_err: got %0b expected 1", err_short_frame); end
    checks++;
    if (frame_count !== 16'd1) begin errors++; $display("FAIL sf_frame_count: got %0h expected 1", frame_count); end
    checks++;
    if (fd_cnt - f0 !== 1) begin errors++; $display("FAIL sf_frame_done: got %0d expected 1", fd_cnt - f0); end
    @(posedge clk); #1 err_clear = 1'b1;
    @(posedge clk); #1 err_clear = 1'b0;
    @(negedge clk);
    checks++;
    if ({err_short_line, err_long_line, err_short_frame, err_overflow} !== 4'b0000) begin
      errors++;
      $display("FAIL sf_err_clear: got %4b expected 0000",
               {err_short_line, err_long_line, err_short_frame, err_overflow});
    end
    $display("test_short_frame done: %0d words", cap_d.size() - s);
  endtask

  task automatic test_reset_mid_frame();
    int s;
    do_reset();
    m_ready = 1'b0; m_ready_b = 1'b0;
    pix_val = 0;
    vs_pulse();
    send_line(6);
    send_line(8);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      href = 1'b1; pixel_in = pix_val[15:0]; pix_val++;
    end
    @(negedge clk);
    checks++;
    if ({err_short_line, err_overflow, m_valid} !== 3'b111) begin
      errors++; $display("FAIL rm_pre_state: got %3b expected 111", {err_short_line, err_overflow, m_valid});
    end
    @(posedge clk); #1;
    rst = 1'b1; href = 1'b0; pixel_in = '0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %0b expected 0", m_valid); end
    checks++;
    if ({err_short_line, err_long_line, err_short_frame, err_overflow} !== 4'b0000) begin
      errors++;
      $display("FAIL rm_errs: got %4b expected 0000",
               {err_short_line, err_long_line, err_short_frame, err_overflow});
    end
    @(posedge clk); #1 rst = 1'b0;
    m_ready = 1'b1; m_ready_b = 1'b1;
    s = cap_d.size(); pix_val = 16'h40;
    send_frame(8, 8, 8, 8);
    idle(10);
    checks++;
    if (cap_d.size() - s !== 32) begin errors++; $display("FAIL rm_count: got %0d expected 32", cap_d.size() - s); end
    checks++;
    if (get_d(s) !== 16'h0040 || get_t(s) !== 3'b001) begin
      errors++; $display("FAIL rm_first: got %0h/%3b expected 40/001", get_d(s), get_t(s));
    end
    checks++;
    if (get_d(s + 31) !== 16'h005F || get_t(s + 31) !== 3'b110) begin
      errors++; $display("FAIL rm_last: got %0h/%3b expected 5f/110", get_d(s + 31), get_t(s + 31));
    end
    checks++;
    if (frame_count !== 16'd1) begin errors++; $display("FAIL rm_frame_count: got %0h expected 1", frame_count); end
    checks++;
    if ({err_short_line, err_long_line, err_short_frame, err_overflow} !== 4'b0000) begin
      errors++;
      $display("FAIL rm_post_errs: got %4b expected 0000",
               {err_short_line, err_long_line, err_short_frame, err_overflow});
    end
    $display("test_reset_mid_frame done: %0d words", cap_d.size() - s);
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b0; href = 1'b0; pixel_in = '0;
    err_clear = 1'b0; m_ready = 1'b1; m_ready_b = 1'b1;
    test_reset();
    test_clean_frame();
    test_backpressure();
    test_short_line();
    test_long_line();
    test_short_frame();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
